clk_gate_ctrl: RTL and testbench

- Enable controller directly upstream of the latch-based clock-gate cell; drives its CLK_EN input.
- Turns the gated domain (e.g. ALU) on when a consumer requests it and waits a fixed wake-up settle time before signalling READY.
- Keeps the clock running through a programmable idle hold-off, then gates it off.
- Maintains a saturating count of enabled cycles for power profiling.

---
 rtl/clk_gate_ctrl_pkg.sv | 24 ++
 rtl/clk_gate_ctrl_if.sv | 25 ++
 rtl/clk_gate_ctrl_sat_counter.sv | 35 +++
 rtl/clk_gate_ctrl.sv | 93 +++++++++
 tb/tb_clk_gate_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/clk_gate_ctrl_pkg.sv
// clk_gate_ctrl shared types: FSM state encoding and counter widths.
// No ports; imported by the controller top.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_WAKE = 2'b01,
    ST_ON   = 2'b10,
    ST_HOLD = 2'b11
  } state_e;

  // WAKE_CYCLES <= 15, IDLE_TIMEOUT <= 255
  localparam int WAKE_W = 4;
  localparam int IDLE_W = 8;

  function automatic logic is_act(
    input logic req,
    input logic busy,
    input logic frc
  );
    return req | busy | frc;
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// clk_gate_ctrl consumer bus: REQ/BUSY/FORCE_ON/CNT_CLR in,
// CLK_EN/READY/ON_CNT out; master = consumer, slave = controller.
interface clk_gate_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic             REQ;
  logic             BUSY;
  logic             FORCE_ON;
  logic             CNT_CLR;
  logic             CLK_EN;
  logic             READY;
  logic [CNT_W-1:0] ON_CNT;

  modport master (
    output REQ, BUSY, FORCE_ON, CNT_CLR,
    input  CLK_EN, READY, ON_CNT
  );

  modport slave (
    input  REQ, BUSY, FORCE_ON, CNT_CLR,
    output CLK_EN, READY, ON_CNT
  );

endinterface

// File: rtl/clk_gate_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats enable).
// Ports: clk_i, rst_ni (sync, active-low), clr_i, en_i, cnt_o.
module clk_gate_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller: wake settle, idle hold-off, ON_CNT.
// Ports: CLK, RST (sync, active-low), bus (slave: consumer signals).
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int WAKE_CYCLES  = 2,
  parameter int IDLE_TIMEOUT = 4,
  parameter int CNT_W        = 16
) (
  input  logic           CLK,
  input  logic           RST,
  clk_gate_ctrl_if.slave bus
);

  localparam logic [WAKE_W-1:0] WAKE_LAST =
    WAKE_W'(WAKE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST =
    IDLE_W'(IDLE_TIMEOUT);

  state_e            state_q;
  logic [WAKE_W-1:0] wake_q;
  logic [IDLE_W-1:0] idle_q;
  logic              clk_en_q;
  logic              ready_q;
  logic              act;

  assign act = is_act(bus.REQ, bus.BUSY, bus.FORCE_ON);

  // idle_q counts idle edges seen while in HOLD; the gate drops
  // on the edge after it reaches IDLE_TIMEOUT, which lands
  // IDLE_TIMEOUT+1 edges after the ON->HOLD edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= ST_OFF;
      wake_q   <= '0;
      idle_q   <= '0;
      clk_en_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (act) begin
            state_q  <= ST_WAKE;
            wake_q   <= '0;
            clk_en_q <= 1'b1;
          end
        end
        ST_WAKE: begin
          // never aborted; act is re-checked in ON
          if (wake_q == WAKE_LAST) begin
            state_q <= ST_ON;
            ready_q <= 1'b1;
          end else begin
            wake_q <= wake_q + WAKE_W'(1);
          end
        end
        ST_ON: begin
          if (!act) begin
            state_q <= ST_HOLD;
            idle_q  <= '0;
          end
        end
        ST_HOLD: begin
          if (act) begin
            state_q <= ST_ON;
            idle_q  <= '0;
          end else if (idle_q == IDLE_LAST) begin
            state_q  <= ST_OFF;
            idle_q   <= '0;
            clk_en_q <= 1'b0;
            ready_q  <= 1'b0;
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.CLK_EN = clk_en_q;
  assign bus.READY  = ready_q;

  clk_gate_ctrl_sat_counter #(
    .W (CNT_W)
  ) u_sat_counter (
    .clk_i  (CLK),
    .rst_ni (RST),
    .clr_i  (bus.CNT_CLR),
    .en_i   (clk_en_q),
    .cnt_o  (bus.ON_CNT)
  );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: vector table plus
// expected-result queue; second instance with CNT_W=4 for saturation.
module tb_clk_gate_ctrl;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  clk_gate_ctrl_if #(.CNT_W(16)) ifa ();
  clk_gate_ctrl_if #(.CNT_W(4))  ifb ();

  clk_gate_ctrl #(
    .WAKE_CYCLES  (2),
    .IDLE_TIMEOUT (4),
    .CNT_W        (16)
  ) dut_a (
    .CLK (clk),
    .RST (rst_a),
    .bus (ifa.slave)
  );

  clk_gate_ctrl #(
    .WAKE_CYCLES  (2),
    .IDLE_TIMEOUT (4),
    .CNT_W        (4)
  ) dut_b (
    .CLK (clk),
    .RST (rst_b),
    .bus (ifb.slave)
  );

  typedef struct {
    bit        rst;
    bit        req;
    bit        busy;
    bit        frc;
    bit        clr;
    bit        en;
    bit        rdy;
    bit [15:0] cnt;
  } vec_t;

  typedef struct {
    bit        en;
    bit        rdy;
    bit [15:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  bit        m_pen = 1'b0;
  bit [15:0] m_cnt = '0;

  // en/rdy are hand-derived; ON_CNT follows from the en history
  task automatic add(
    input bit rst, input bit req, input bit busy,
    input bit frc, input bit clr,
    input bit en, input bit rdy
  );
    vec_t v;
    if (!rst) m_cnt = '0;
    else if (clr) m_cnt = '0;
    else if (m_pen && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_pen = en;
    v = '{rst, req, busy, frc, clr, en, rdy, m_cnt};
    vecs.push_back(v);
  endtask

  task automatic check_out(
    input string tag, input int idx,
    input bit en, input bit rdy, input bit [15:0] cnt
  );
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s[%0d] scoreboard empty", tag, idx);
    end else begin
      e = sb.pop_front();
      if (en !== e.en || rdy !== e.rdy || cnt !== e.cnt)
        $display("FAIL %s[%0d] en/rdy/cnt got %b/%b/%0d want %b/%b/%0d",
                 tag, idx, en, rdy, cnt, e.en, e.rdy, e.cnt);
      else
        passed++;
    end
  endtask

  task automatic wake(input bit req, input bit busy, input bit frc);
    add(1, req, busy, frc, 0, 1, 0);
    add(1, req, busy, frc, 0, 1, 0);
    add(1, req, busy, frc, 0, 1, 1);
  endtask

  task automatic idle_off();
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    exp_t e;
    ifa.REQ = 0; ifa.BUSY = 0; ifa.FORCE_ON = 0; ifa.CNT_CLR = 0;
    ifb.REQ = 0; ifb.BUSY = 0; ifb.FORCE_ON = 0; ifb.CNT_CLR = 0;

    // reset beats active inputs, then long idle
    for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) add(1, 0, 0, 0, 0, 0, 0);
    // wake latency and ON
    wake(1, 0, 0);
    for (int i = 0; i < 17; i++) add(1, 1, 0, 0, 0, 1, 1);
    // idle gate-off
    idle_off();
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0);
    // BUSY re-activates from HOLD, no gate-off
    wake(1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) add(1, 0, 1, 0, 0, 1, 1);
    idle_off();
    // act on the would-be timeout edge keeps the clock
    wake(1, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 1, 1);
    idle_off();
    // REQ re-rising right after gate-off: full wake
    wake(1, 0, 0);
    // counter clear
    add(1, 1, 0, 0, 1, 1, 1);
    add(1, 1, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 1, 1);
    // WAKE completes even if REQ drops
    idle_off();
    add(1, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 1);
    idle_off();
    // reset mid-WAKE, then full wake again
    add(1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    wake(1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1);
    idle_off();
    // FORCE_ON takes the same wake path
    wake(0, 0, 1);
    add(1, 0, 0, 1, 0, 1, 1);
    idle_off();

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_a        = vecs[i].rst;
      ifa.REQ      = vecs[i].req;
      ifa.BUSY     = vecs[i].busy;
      ifa.FORCE_ON = vecs[i].frc;
      ifa.CNT_CLR  = vecs[i].clr;
      e = '{vecs[i].en, vecs[i].rdy, vecs[i].cnt};
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out("vecA", i, ifa.CLK_EN, ifa.READY, ifa.ON_CNT);
    end

    // CNT_W=4: saturate at 15 under FORCE_ON, then clear
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      rst_b        = 1'b1;
      ifb.FORCE_ON = 1'b1;
      ifb.CNT_CLR  = (k == 31);
      if (k <= 30)
        e = '{1'b1, k >= 3, (k - 1 > 15) ? 16'd15 : 16'(k - 1)};
      else
        e = '{1'b1, 1'b1, 16'(k - 31)};
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out("satB", k, ifb.CLK_EN, ifb.READY, {12'd0, ifb.ON_CNT});
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
